// File: rtl/uart_tx_10b_if.sv
// Signal bundle between the flit encoder (master) and the serial transmitter (slave).
interface uart_tx_10b_if #(
    parameter int SYM_W    = 10,
    parameter int MAX_SYMS = 6
) ();
    logic                      start;
    logic [SYM_W*MAX_SYMS-1:0] enc_flit;
    logic                      comma_length_sel;
    logic                      serial_out;
    logic                      busy;
    logic                      done;
    logic                      start_drop;

    modport master (
        output start, enc_flit, comma_length_sel,
        input  serial_out, busy, done, start_drop
    );

    modport slave (
        input  start, enc_flit, comma_length_sel,
        output serial_out, busy, done, start_drop
    );
endinterface

// File: rtl/uart_tx_10b.sv
// UART-style framer for 10-bit encoded symbols: start, 10 data bits LSB first, stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_10b #(
    parameter int CLKS_PER_BIT = 4,
    parameter int SYM_W        = 10,
    parameter int MAX_SYMS     = 6
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_10b_if.slave   bus
);
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam int SYM_CW = (MAX_SYMS > 1) ? $clog2(MAX_SYMS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [BIT_W-1:0]          bit_q;
    logic [SYM_CW-1:0]         sym_q;
    logic [SYM_CW-1:0]         last_q;
    logic [SYM_W*MAX_SYMS-1:0] flit_q;
    logic [SYM_W-1:0]          sym_cur;
    logic                      bit_end;
    logic                      accept;
    logic                      serial_d;
    logic                      busy_d;
    logic                      done_d;

    // The current symbol always sits in the low slot; the flit shifts down per symbol.
    assign sym_cur = flit_q[SYM_W-1:0];
    assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        serial_d = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                busy_d = 1'b0;
                done_d = (state_q == S_DONE);
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                serial_d = 1'b0;
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                serial_d = sym_cur[bit_q];
                if (bit_end && bit_q == BIT_W'(SYM_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                serial_d = ^sym_cur;
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                serial_d = 1'b1;
                if (bit_end) state_d = (sym_q == last_q) ? S_DONE : S_START;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sym_q   <= '0;
            last_q  <= '0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                flit_q <= bus.enc_flit;
                last_q <= bus.comma_length_sel ? SYM_CW'(MAX_SYMS - 1) : '0;
                sym_q  <= '0;
                cnt_q  <= '0;
                bit_q  <= '0;
            end else if (state_q != S_IDLE && state_q != S_DONE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                if (state_q == S_DATA && bit_end)
                    bit_q <= (bit_q == BIT_W'(SYM_W - 1)) ? '0 : bit_q + 1'b1;
                if (state_q == S_STOP && bit_end && sym_q != last_q) begin
                    sym_q  <= sym_q + 1'b1;
                    flit_q <= flit_q >> SYM_W;
                end
            end
        end
    end

    assign bus.serial_out = serial_d;
    assign bus.busy       = busy_d;
    assign bus.done       = done_d;
    assign bus.start_drop = bus.start & busy_d;
endmodule

// File: tb/tb_uart_tx_10b.sv
// Directed self-checking bench for uart_tx_10b (CPB=4); table-driven comma frame plus
// hand-written full-frame, collision, back-to-back and mid-frame reset sequences.
module tb_uart_tx_10b;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int BITS_PER_SYM = 13;
`else
    localparam int BITS_PER_SYM = 12;
`endif
    localparam int SYMC = BITS_PER_SYM * CPB;
    localparam int D1   = 1 + SYMC;
    localparam int D6   = 1 + 6 * SYMC;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_10b_if #(.SYM_W(10), .MAX_SYMS(6)) bus ();

    uart_tx_10b #(.CLKS_PER_BIT(CPB), .SYM_W(10), .MAX_SYMS(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int   off;
        logic ser;
        logic busy;
        logic done;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;

    logic [59:0] flit_comma;
    logic [59:0] flit_full;
    logic [9:0]  exp_syms [6];
    logic        comma_bits [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_to(input int k);
        while (cur < k) begin
            @(negedge CLK);
            cur++;
        end
    endtask

    // Called at a negedge while idle; returns in cycle t+1 with junk on the data inputs.
    task automatic accept(input logic [59:0] flit, input logic sel);
        bus.start            = 1'b1;
        bus.enc_flit         = flit;
        bus.comma_length_sel = sel;
        @(posedge CLK);
        @(negedge CLK);
        bus.start            = 1'b0;
        bus.enc_flit         = '1;
        bus.comma_length_sel = ~sel;
        cur = 1;
    endtask

    task automatic run_table(input string tag);
        accept(flit_comma, 1'b0);
        foreach (tbl[i]) begin
            step_to(tbl[i].off);
            chk($sformatf("%s ser@%0d", tag, tbl[i].off), {31'd0, bus.serial_out}, {31'd0, tbl[i].ser});
            chk($sformatf("%s busy@%0d", tag, tbl[i].off), {31'd0, bus.busy}, {31'd0, tbl[i].busy});
            chk($sformatf("%s done@%0d", tag, tbl[i].off), {31'd0, bus.done}, {31'd0, tbl[i].done});
        end
    endtask

    initial begin
        logic [9:0] rx [6];
        int         frame_err;
        int         early_done;
        int         late_done;
        int         stop_off;

        flit_comma = {50'h3_FFFF_FFFF_FFFF, 10'h0FA};
        flit_full  = {10'h0FA, 10'h2AA, 10'h155, 10'h3FF, 10'h000, 10'h2D4};
        exp_syms   = '{10'h2D4, 10'h000, 10'h3FF, 10'h155, 10'h2AA, 10'h0FA};
        comma_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        tbl.push_back('{1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{4, 1'b0, 1'b1, 1'b0});
        for (int k = 0; k < 10; k++) begin
            tbl.push_back('{5 + 4 * k, comma_bits[k], 1'b1, 1'b0});
            tbl.push_back('{8 + 4 * k, comma_bits[k], 1'b1, 1'b0});
        end
        stop_off = 45;
`ifdef UART_TX_PARITY_EN
        // 0x0FA carries six ones, so the even-parity bit is 0.
        tbl.push_back('{45, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{48, 1'b0, 1'b1, 1'b0});
        stop_off = 49;
`endif
        tbl.push_back('{stop_off, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{stop_off + 3, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{D1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{D1 + 1, 1'b1, 1'b0, 1'b0});

        bus.start            = 1'b0;
        bus.enc_flit         = '0;
        bus.comma_length_sel = 1'b0;

        // Reset
        repeat (2) @(negedge CLK);
        chk("rst serial", {31'd0, bus.serial_out}, 32'd1);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst done", {31'd0, bus.done}, 32'd0);
        chk("rst drop", {31'd0, bus.start_drop}, 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle serial", {31'd0, bus.serial_out}, 32'd1);
        chk("idle busy", {31'd0, bus.busy}, 32'd0);

        // Comma-only frame
        run_table("comma");

        // Full frame with a colliding start at t+20
        accept(flit_full, 1'b1);
        frame_err  = 0;
        early_done = 0;
        for (int s = 0; s < 6; s++) rx[s] = '0;
        for (int off = 1; off <= D6; off++) begin
            int rel, s, pos;
            step_to(off);
            if (off == 20) begin
                bus.start = 1'b1;
                #1 chk("drop@20", {31'd0, bus.start_drop}, 32'd1);
            end else if (off == 21) begin
                bus.start = 1'b0;
                #1 chk("drop@21", {31'd0, bus.start_drop}, 32'd0);
            end
            if (off < D6) begin
                if (bus.done !== 1'b0 || bus.busy !== 1'b1) early_done++;
                rel = (off - 1) % SYMC;
                s   = (off - 1) / SYMC;
                pos = rel / CPB;
                if (rel % CPB == 2) begin
                    if (pos == 0) begin
                        if (bus.serial_out !== 1'b0) frame_err++;
                    end else if (pos <= 10) begin
                        rx[s][pos - 1] = bus.serial_out;
                    end else if (pos == BITS_PER_SYM - 1) begin
                        if (bus.serial_out !== 1'b1) frame_err++;
                    end else begin
                        if (bus.serial_out !== ^exp_syms[s]) frame_err++;
                    end
                end
            end
        end
        chk("full done", {31'd0, bus.done}, 32'd1);
        chk("full busy", {31'd0, bus.busy}, 32'd0);
        chk("full framing", frame_err, 0);
        chk("full early_done/busy", early_done, 0);
        for (int s = 0; s < 6; s++)
            chk($sformatf("full sym%0d", s), {22'd0, rx[s]}, {22'd0, exp_syms[s]});
        late_done = 0;
        repeat (6) begin
            @(negedge CLK);
            if (bus.done !== 1'b0) late_done++;
        end
        chk("full single done", late_done, 0);

        // Back-to-back: start raised in the DONE cycle
        accept(flit_comma, 1'b0);
        step_to(D1);
        chk("b2b done1", {31'd0, bus.done}, 32'd1);
        bus.start            = 1'b1;
        bus.enc_flit         = {50'd0, 10'h155};
        bus.comma_length_sel = 1'b0;
        #1 chk("b2b no drop", {31'd0, bus.start_drop}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        bus.start = 1'b0;
        cur = D1 + 1;
        chk("b2b start first", {31'd0, bus.serial_out}, 32'd0);
        chk("b2b busy", {31'd0, bus.busy}, 32'd1);
        step_to(D1 + 4);
        chk("b2b start last", {31'd0, bus.serial_out}, 32'd0);
        step_to(D1 + 5);
        chk("b2b bit0", {31'd0, bus.serial_out}, 32'd1);
        step_to(D1 + 9);
        chk("b2b bit1", {31'd0, bus.serial_out}, 32'd0);
        step_to(2 * D1);
        chk("b2b done2", {31'd0, bus.done}, 32'd1);
        @(negedge CLK);

        // Reset mid-frame
        accept(flit_full, 1'b1);
        step_to(30);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst serial", {31'd0, bus.serial_out}, 32'd1);
        chk("midrst busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst done", {31'd0, bus.done}, 32'd0);
        RST = 1'b0;
        late_done = 0;
        repeat (D6 + 10) begin
            @(negedge CLK);
            if (bus.done !== 1'b0 || bus.serial_out !== 1'b1 || bus.busy !== 1'b0) late_done++;
        end
        chk("midrst quiet", late_done, 0);
        run_table("post-rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
